pio_host_loader: RTL and testbench
==================================

Name: pio_host_loader

Overview:
- Upstream command front-end for the pio block; sits between a byte-stream host link (UART/SPI receiver) and pio's configuration port.
- Parses framed byte packets into single-cycle action/index/mindex/din strobes that load instructions, configure machines, push/pull FIFO data and issue immediate instructions.
- For pull commands, captures pio dout and returns it to the host as a 4-byte response stream.

Parameters:
- TIMEOUT, 100000, max idle cycles between bytes of one packet before abort (>=2)
- PULL_LATENCY, 2, cycles from action=3 strobe to sampling pio_dout (1..7)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (low = in reset)
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer when rx_valid & rx_ready
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host accepts byte; transfer when tx_valid & tx_ready
- action  out  4  pio action strobe; nonzero for exactly one cycle per command
- index  out  5  pio index
- mindex  out  2  pio machine index
- din  out  32  pio data
- pio_dout  in  32  pio read data
- busy  out  1  high whenever state != IDLE
- err_count  out  8  saturating count of rejected/aborted packets

Behaviour:
- Reset (async assert, sync release): state IDLE; action=0, index=0, mindex=0, din=0, tx_data=0, tx_valid=0, rx_ready=0 during reset, err_count=0, busy=0.
- Packet: byte0 = {2'b00 reserved, mindex[1:0], action[3:0]}; byte1 = {3'b0, index[4:0]}; then payload, little-endian into din[8k+7:8k]; unsent din bytes zero.
- Payload length by action: 1 instr=2, 2 pend=0, 3 pull=0, 4 push=4, 5 pins=1, 6 enable=1, 7 div=3, 9 imm=2. Any other action (0,8,10-15): byte0 consumed, packet rejected, err_count+1, return to IDLE; index byte not expected.
- Reserved bits byte0[7:6] or byte1[7:5] nonzero: packet rejected as above at the offending byte.
- States: IDLE -> INDEX (byte0 accepted, valid action) -> PAYLOAD (if length>0) -> ISSUE -> IDLE, or ISSUE -> WAIT_RD -> SEND -> IDLE for pull.
- rx_ready=1 only in IDLE/INDEX/PAYLOAD; 0 in ISSUE/WAIT_RD/SEND.
- Latency: last byte of packet accepted in cycle N -> action/index/mindex/din valid in cycle N+1 only; action returns to 0 in N+2; loader back in IDLE at N+2 (rx_ready=1). index/mindex/din hold last values between strobes.
- Pull: strobe action=3 at N+1; pio_dout sampled exactly PULL_LATENCY cycles after strobe cycle; then SEND drives 4 bytes LSB first, tx_valid held until each handshake, tx_data stable while tx_valid & !tx_ready. After 4th handshake, tx_valid=0, IDLE next cycle.
- Timeout: in INDEX/PAYLOAD, counter reset on each accepted byte; reaching TIMEOUT cycles with no byte -> abort to IDLE, no strobe, err_count+1. Counter idle in other states.
- err_count saturates at 255.
- Reset mid-packet or mid-SEND: all state dropped immediately, partial response discarded, no strobe emitted.
- No back-to-back overlap: a new byte0 cannot be accepted before the previous command's strobe cycle completes.

Test Plan:
- Instr load: bytes 0x01,0x05,0x34,0x12 -> one cycle action=1, index=5, mindex=0, din=0x00001234, one cycle after last byte; rx_ready low that cycle only.
- Div config: 0x27,0x00,0x10,0x00,0x01 -> action=7, mindex=2, din=0x00010010; then pend 0x12,0x1F -> action=2, mindex=1, index=31, din=0.
- Pull: 0x03,0x00 with pio_dout=0xDEADBEEF sampled PULL_LATENCY=2 after strobe -> tx bytes 0xEF,0xBE,0xAD,0xDE; hold tx_ready low 3 cycles on byte 2 -> tx_data stable 0xAD.
- Reject: byte0=0x08 -> no strobe, err_count=1, next byte treated as byte0; byte0=0x41 -> rejected, err_count=2.
- Timeout: TIMEOUT=16, send 0x04,0x00,0xAA then silence 16 cycles -> IDLE, err_count+1, no action=4 strobe; following full push packet issues normally.
- Reset: assert reset low during SEND after 2 bytes -> tx_valid=0, busy=0, all outputs zero immediately, no further bytes after release.

Source files
------------

// File: rtl/pio_host_loader_if.sv
// pio_host_loader_if
//   Bundles the host byte link, the response byte link, the pio configuration
//   port and the loader status signals into one interface.
//
//   Handshake rule for both byte links: a byte moves on a rising clock edge
//   where valid and ready are both high. The sender holds valid and the data
//   stable until that edge. The receiver may raise or drop ready at any time.
//
//   Signals:
//     rx_data/rx_valid/rx_ready : host -> loader command bytes
//     tx_data/tx_valid/tx_ready : loader -> host response bytes
//     action/index/mindex/din   : pio configuration strobe and operands
//     pio_dout                  : pio read data, sampled for pull commands
//     busy/err_count            : loader status
//   Modports:
//     slave  : the loader's view
//     master : the host/pio side (testbench) view
interface pio_host_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din;
    logic [31:0] pio_dout;
    logic        busy;
    logic [7:0]  err_count;

    modport slave (
        input  rx_data, rx_valid, tx_ready, pio_dout,
        output rx_ready, tx_data, tx_valid, action, index, mindex, din,
               busy, err_count
    );

    modport master (
        output rx_data, rx_valid, tx_ready, pio_dout,
        input  rx_ready, tx_data, tx_valid, action, index, mindex, din,
               busy, err_count
    );
endinterface

// File: rtl/pio_host_loader.sv
// pio_host_loader
//   Parses framed host byte packets into single-cycle pio configuration
//   strobes. Packet: byte0 = {2'b00, mindex, action}, byte1 = {3'b000, index},
//   then 0..4 payload bytes, little-endian into din. A pull command (action 3)
//   samples pio_dout PULL_LATENCY cycles after its strobe and returns it to
//   the host as four bytes, LSB first.
//
//   Ports:
//     clk       : system clock
//     reset     : asynchronous active-low reset
//     bus       : pio_host_loader_if.slave (byte links, pio port, status)
//     state_dbg : current FSM state encoding
module pio_host_loader #(
    parameter int TIMEOUT      = 100000,
    parameter int PULL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    pio_host_loader_if.slave bus,
    output logic [2:0]       state_dbg
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INDEX   = 3'd1,
        S_PAYLOAD = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT_RD = 3'd4,
        S_SEND    = 3'd5
    } state_t;

    function automatic logic [2:0] pay_len(input logic [3:0] a);
        case (a)
            4'd1:       return 3'd2;
            4'd4:       return 3'd4;
            4'd5, 4'd6: return 3'd1;
            4'd7:       return 3'd3;
            4'd9:       return 3'd2;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic logic act_ok(input logic [3:0] a);
        return (a >= 4'd1 && a <= 4'd7) || (a == 4'd9);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cmd_act_q;
    logic [1:0]  cmd_mi_q;
    logic [4:0]  cmd_idx_q;
    logic [2:0]  len_q;
    logic [1:0]  pos_q;
    logic [31:0] acc_q;
    logic [TW-1:0] tmo_q;
    logic [2:0]  rd_q;
    logic [31:0] resp_q;
    logic [1:0]  tx_cnt_q;
    logic [3:0]  action_q;
    logic [4:0]  index_q;
    logic [1:0]  mindex_q;
    logic [31:0] din_q;
    logic [7:0]  err_q;

    logic        rx_ready_w, tx_valid_w, rx_fire, tx_fire, tmo_hit;
    logic        strobe, err_inc;
    logic [31:0] din_next;

    // rx_ready is gated by reset so the host sees no acceptance while held.
    assign rx_ready_w = reset && (state_q == S_IDLE || state_q == S_INDEX ||
                                  state_q == S_PAYLOAD);
    assign tx_valid_w = (state_q == S_SEND);
    assign rx_fire    = bus.rx_valid && rx_ready_w;
    assign tx_fire    = tx_valid_w && bus.tx_ready;
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
    assign din_next   = acc_q | ({24'h0, bus.rx_data} << {pos_q, 3'b000});

    assign bus.rx_ready  = rx_ready_w;
    assign bus.tx_valid  = tx_valid_w;
    assign bus.tx_data   = tx_valid_w ? resp_q[{tx_cnt_q, 3'b000} +: 8] : 8'h00;
    assign bus.action    = action_q;
    assign bus.index     = index_q;
    assign bus.mindex    = mindex_q;
    assign bus.din       = din_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err_count = err_q;
    assign state_dbg     = state_q;

    always_comb begin
        state_d = state_q;
        strobe  = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (bus.rx_data[7:6] == 2'b00 && act_ok(bus.rx_data[3:0]))
                        state_d = S_INDEX;
                    else
                        err_inc = 1'b1;
                end
            end
            S_INDEX: begin
                if (rx_fire) begin
                    if (bus.rx_data[7:5] != 3'b000) begin
                        err_inc = 1'b1;
                        state_d = S_IDLE;
                    end else if (len_q == 3'd0) begin
                        strobe  = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (rx_fire) begin
                    if ({1'b0, pos_q} == len_q - 3'd1) begin
                        strobe  = 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ISSUE:   state_d = (cmd_act_q == 4'd3) ? S_WAIT_RD : S_IDLE;
            S_WAIT_RD: if (rd_q == 3'(PULL_LATENCY)) state_d = S_SEND;
            S_SEND:    if (tx_fire && tx_cnt_q == 2'd3) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cmd_act_q <= 4'd0;
            cmd_mi_q  <= 2'd0;
            cmd_idx_q <= 5'd0;
            len_q     <= 3'd0;
            pos_q     <= 2'd0;
            acc_q     <= 32'd0;
            tmo_q     <= '0;
            rd_q      <= 3'd0;
            resp_q    <= 32'd0;
            tx_cnt_q  <= 2'd0;
            action_q  <= 4'd0;
            index_q   <= 5'd0;
            mindex_q  <= 2'd0;
            din_q     <= 32'd0;
            err_q     <= 8'd0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && rx_fire) begin
                cmd_act_q <= bus.rx_data[3:0];
                cmd_mi_q  <= bus.rx_data[5:4];
                len_q     <= pay_len(bus.rx_data[3:0]);
                acc_q     <= 32'd0;
                pos_q     <= 2'd0;
            end
            if (state_q == S_INDEX && rx_fire)
                cmd_idx_q <= bus.rx_data[4:0];
            if (state_q == S_PAYLOAD && rx_fire) begin
                acc_q <= din_next;
                pos_q <= pos_q + 2'd1;
            end

            // Idle-gap counter only runs while a packet is partially received.
            if ((state_q == S_INDEX || state_q == S_PAYLOAD) && !rx_fire)
                tmo_q <= tmo_q + TW'(1);
            else
                tmo_q <= '0;

            // Operands are registered with the strobe so they appear in the
            // same cycle and then hold until the next command.
            action_q <= strobe ? cmd_act_q : 4'd0;
            if (strobe) begin
                index_q  <= (state_q == S_INDEX) ? bus.rx_data[4:0] : cmd_idx_q;
                mindex_q <= cmd_mi_q;
                din_q    <= (state_q == S_INDEX) ? 32'd0 : din_next;
            end

            // rd_q counts cycles since the strobe; capture when it reaches
            // PULL_LATENCY.
            if (state_q == S_ISSUE)
                rd_q <= 3'd1;
            else if (state_q == S_WAIT_RD) begin
                if (rd_q == 3'(PULL_LATENCY))
                    resp_q <= bus.pio_dout;
                else
                    rd_q <= rd_q + 3'd1;
            end

            if (state_q == S_ISSUE)
                tx_cnt_q <= 2'd0;
            else if (tx_fire)
                tx_cnt_q <= tx_cnt_q + 2'd1;

            if (err_inc && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_pio_host_loader.sv
// tb_pio_host_loader
//   Self-checking bench for pio_host_loader: table-driven packet vectors,
//   directed pull / timeout / saturation / reset sequences, and randomized
//   packets checked against a packet-level reference model.
module tb_pio_host_loader;
    localparam int TO = 16;
    localparam int PL = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pio_host_loader_if bus ();
    logic [2:0] state_dbg;

    pio_host_loader #(.TIMEOUT(TO), .PULL_LATENCY(PL)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    int exp_err = 0;
    logic [42:0] exp_q[$];     // {action, index, mindex, din}
    logic [7:0]  exp_tx_q[$];

    int last_acc_cyc = 0;
    int strobe_cnt   = 0;
    int strobe3_cyc  = -100;
    int tx_hs        = 0;
    logic prev_act_nz = 1'b0;
    logic held_valid  = 1'b0;
    logic [7:0] held_tx = 8'h00;

    int tx_mode = 0;           // 0: ready high, 1: random, 2: ready low
    logic dout_timed = 1'b0;
    logic [31:0] const_dout = 32'h0;
    logic [31:0] pull_target = 32'h0;

    int plen_tab[16] = '{-1, 2, 0, 0, 4, 1, 1, 3, -1, 2, -1, -1, -1, -1, -1, -1};
    logic [3:0] good_act[8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    logic [3:0] bad_act[8]  = '{4'd0, 4'd8, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Reference model: decides from the packet framing rules how many bytes
    // the loader consumes and what strobe (if any) results.
    function automatic void model(input logic [5:0][7:0] b, output int n,
                                  output logic ok, output logic [42:0] rec);
        int L;
        logic [31:0] d;
        L   = plen_tab[b[0][3:0]];
        d   = 32'h0;
        ok  = 1'b0;
        rec = '0;
        if (b[0][7:6] != 2'b00 || L < 0) begin
            n = 1;
            return;
        end
        if (b[1][7:5] != 3'b000) begin
            n = 2;
            return;
        end
        n  = 2 + L;
        ok = 1'b1;
        for (int k = 0; k < L; k++) d = d + (32'(b[2 + k]) << (8 * k));
        rec = {b[0][3:0], b[1][4:0], b[0][5:4], d};
    endfunction

    // ---------------- input drivers (tx_ready, pio_dout) ----------------
    always @(posedge clk) begin
        #1;
        case (tx_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = 1'b0;
        endcase
        if (dout_timed)
            bus.pio_dout = (cyc == strobe3_cyc + PL) ? pull_target : ~pull_target;
        else
            bus.pio_dout = const_dout;
    end

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (reset && bus.action != 4'd0) begin
            strobe_cnt++;
            if (bus.action == 4'd3) strobe3_cyc = cyc;
            chk("strobe_latency", 64'(cyc), 64'(last_acc_cyc + 1));
            chk("strobe_rx_ready_low", bus.rx_ready, 0);
            chk("strobe_single_cycle", prev_act_nz, 0);
            if (exp_q.size() == 0)
                chk("unexpected_strobe", bus.action, 0);
            else
                chk("strobe_fields", {bus.action, bus.index, bus.mindex, bus.din},
                    exp_q.pop_front());
        end
        prev_act_nz = (bus.action != 4'd0);
    end

    always @(negedge clk) begin
        if (held_valid && reset) begin
            chk("tx_valid_held", bus.tx_valid, 1);
            chk("tx_data_stable", bus.tx_data, held_tx);
        end
        if (reset && bus.tx_valid && bus.tx_ready) begin
            tx_hs++;
            if (exp_tx_q.size() == 0)
                chk("unexpected_tx", bus.tx_valid, 0);
            else
                chk("tx_byte", bus.tx_data, exp_tx_q.pop_front());
        end
        held_valid = reset && bus.tx_valid && !bus.tx_ready;
        held_tx    = bus.tx_data;
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.rx_ready) chk("rx_ready_wait_expired", bus.rx_ready, 1);
        last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [5:0][7:0] b, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            send_byte(b[i]);
            if (i < n - 1 && maxgap > 0) idle_cycles($urandom_range(0, maxgap));
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (bus.busy && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (bus.busy) chk("idle_wait_expired", bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int              n;
        logic [5:0][7:0] b;
        logic            st;
        logic [42:0]     exp;
        int              err_inc;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input int n, input logic [7:0] b0, b1, b2, b3, b4, b5,
                           input logic st, input logic [3:0] a, input logic [4:0] ix,
                           input logic [1:0] mi, input logic [31:0] d, input int e);
        vec_t v;
        v.n       = n;
        v.b       = {b5, b4, b3, b2, b1, b0};
        v.st      = st;
        v.exp     = {a, ix, mi, d};
        v.err_inc = e;
        vecs.push_back(v);
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [5:0][7:0] pb;
        int n, s0, hs0, w, r;
        logic ok;
        logic [42:0] rec;
        logic [3:0] a;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        add_vec(4, 8'h01, 8'h05, 8'h34, 8'h12, 0, 0, 1, 4'd1, 5'd5, 2'd0, 32'h0000_1234, 0);
        add_vec(5, 8'h27, 8'h00, 8'h10, 8'h00, 8'h01, 0, 1, 4'd7, 5'd0, 2'd2, 32'h0001_0010, 0);
        add_vec(2, 8'h12, 8'h1F, 0, 0, 0, 0, 1, 4'd2, 5'd31, 2'd1, 32'h0, 0);
        add_vec(1, 8'h08, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 2'd0, 32'h0, 1);
        add_vec(4, 8'h01, 8'h03, 8'hAA, 8'h55, 0, 0, 1, 4'd1, 5'd3, 2'd0, 32'h0000_55AA, 0);
        add_vec(1, 8'h41, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 2'd0, 32'h0, 1);
        add_vec(6, 8'h34, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 1, 4'd4, 5'd2, 2'd3, 32'h4433_2211, 0);
        add_vec(3, 8'h05, 8'h1A, 8'h7E, 0, 0, 0, 1, 4'd5, 5'd26, 2'd0, 32'h0000_007E, 0);
        add_vec(3, 8'h16, 8'h04, 8'h0F, 0, 0, 0, 1, 4'd6, 5'd4, 2'd1, 32'h0000_000F, 0);
        add_vec(4, 8'h09, 8'h11, 8'hE0, 8'h01, 0, 0, 1, 4'd9, 5'd17, 2'd0, 32'h0000_01E0, 0);
        add_vec(2, 8'h01, 8'h25, 0, 0, 0, 0, 0, 4'd0, 5'd0, 2'd0, 32'h0, 1);
        add_vec(1, 8'h00, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 2'd0, 32'h0, 1);
        add_vec(1, 8'h1F, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 2'd0, 32'h0, 1);
        add_vec(1, 8'h81, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 2'd0, 32'h0, 1);

        // Reset state
        #3 reset = 1'b0;
        #20;
        chk("reset_strobe_outs", {bus.action, bus.index, bus.mindex, bus.din}, 43'h0);
        chk("reset_tx", {bus.tx_valid, bus.tx_data}, 9'h0);
        chk("reset_status", {bus.rx_ready, bus.busy, bus.err_count}, 10'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven packets
        foreach (vecs[i]) begin
            if (vecs[i].st) exp_q.push_back(vecs[i].exp);
            s0 = strobe_cnt;
            send_pkt(vecs[i].b, vecs[i].n, 0);
            @(negedge clk);
            @(negedge clk);
            exp_err = exp_err + vecs[i].err_inc;
            chk($sformatf("vec%0d_rx_ready_back", i), bus.rx_ready, 1);
            chk($sformatf("vec%0d_busy", i), bus.busy, 0);
            chk($sformatf("vec%0d_strobes", i), 64'(strobe_cnt - s0), 64'(vecs[i].st));
            chk($sformatf("vec%0d_err_count", i), bus.err_count, 64'(exp_err));
            if (vecs[i].st)
                chk($sformatf("vec%0d_operands_hold", i), {bus.index, bus.mindex, bus.din},
                    vecs[i].exp[38:0]);
            @(posedge clk);
            #1;
        end

        // Pull with exact sampling cycle and a 3-cycle stall on 0xAD
        wait_idle();
        dout_timed  = 1'b1;
        pull_target = 32'hDEAD_BEEF;
        tx_mode     = 0;
        exp_q.push_back({4'd3, 5'd0, 2'd0, 32'h0});
        exp_tx_q.push_back(8'hEF);
        exp_tx_q.push_back(8'hBE);
        exp_tx_q.push_back(8'hAD);
        exp_tx_q.push_back(8'hDE);
        send_byte(8'h03);
        send_byte(8'h00);
        w = 0;
        @(negedge clk);
        while (!(bus.tx_valid && bus.tx_data == 8'hBE) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("pull_second_byte_seen", bus.tx_data, 8'hBE);
        tx_mode = 2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("pull_stall_data", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hAD});
        end
        tx_mode = 0;
        wait_idle();
        chk("pull_all_bytes_sent", exp_tx_q.size(), 0);
        chk("pull_tx_valid_low", bus.tx_valid, 0);
        dout_timed = 1'b0;

        // Timeout mid-packet, then a full push packet
        s0 = strobe_cnt;
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'hAA);
        repeat (16) @(negedge clk);
        chk("timeout_busy_before", bus.busy, 1);
        @(negedge clk);
        exp_err = sat_inc(exp_err);
        chk("timeout_busy_after", bus.busy, 0);
        chk("timeout_err_count", bus.err_count, 64'(exp_err));
        chk("timeout_no_strobe", 64'(strobe_cnt - s0), 0);
        @(posedge clk);
        #1;
        exp_q.push_back({4'd4, 5'd1, 2'd0, 32'h0403_0201});
        pb = {8'h04, 8'h03, 8'h02, 8'h01, 8'h01, 8'h04};
        send_pkt(pb, 6, 0);
        wait_idle();
        chk("push_after_timeout", 64'(strobe_cnt - s0), 1);

        // Randomized packets against the reference model
        tx_mode = 1;
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            r = $urandom_range(0, 9);
            a = (r == 0) ? bad_act[$urandom_range(0, 7)] : good_act[$urandom_range(0, 7)];
            pb[0] = {(r == 1) ? 2'($urandom_range(1, 3)) : 2'b00, 2'($urandom_range(0, 3)), a};
            pb[1] = {(r == 2) ? 3'($urandom_range(1, 7)) : 3'b000, 5'($urandom_range(0, 31))};
            for (int k = 2; k < 6; k++) pb[k] = 8'($urandom_range(0, 255));
            model(pb, n, ok, rec);
            if (ok) begin
                exp_q.push_back(rec);
                if (a == 4'd3) begin
                    const_dout = $urandom;
                    for (int k = 0; k < 4; k++) exp_tx_q.push_back(const_dout[8 * k +: 8]);
                end
            end else begin
                exp_err = sat_inc(exp_err);
            end
            send_pkt(pb, n, 3);
        end
        wait_idle();
        tx_mode = 0;
        wait_idle();
        chk("random_err_count", bus.err_count, 64'(exp_err));
        chk("random_strobes_drained", exp_q.size(), 0);
        chk("random_tx_drained", exp_tx_q.size(), 0);

        // err_count saturation
        while (exp_err < 258) begin
            send_byte(8'h08);
            exp_err = exp_err + 1;
        end
        @(negedge clk);
        chk("err_count_saturated", bus.err_count, 8'hFF);
        @(posedge clk);
        #1;

        // Reset during SEND after two bytes
        wait_idle();
        const_dout = 32'hCAFE_F00D;
        exp_q.push_back({4'd3, 5'd7, 2'd1, 32'h0});
        exp_tx_q.push_back(8'h0D);
        exp_tx_q.push_back(8'hF0);
        exp_tx_q.push_back(8'hFE);
        exp_tx_q.push_back(8'hCA);
        send_byte(8'h13);
        send_byte(8'h07);
        w = 0;
        @(negedge clk);
        while (!(bus.tx_valid && bus.tx_data == 8'hF0) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("reset_test_second_byte_seen", bus.tx_data, 8'hF0);
        tx_mode = 2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_tx_q.delete();
        exp_err = 0;
        chk("midsend_reset_tx", {bus.tx_valid, bus.tx_data}, 9'h0);
        chk("midsend_reset_status", {bus.busy, bus.rx_ready, bus.err_count}, 10'h0);
        chk("midsend_reset_outs", {bus.action, bus.index, bus.mindex, bus.din}, 43'h0);
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        tx_mode = 0;
        hs0 = tx_hs;
        s0  = strobe_cnt;
        repeat (20) @(negedge clk);
        chk("after_reset_no_tx", 64'(tx_hs - hs0), 0);
        chk("after_reset_no_strobe", 64'(strobe_cnt - s0), 0);
        chk("after_reset_idle", {bus.busy, bus.tx_valid, bus.rx_ready}, 3'b001);

        chk("final_exp_q_empty", exp_q.size(), 0);
        chk("final_exp_tx_q_empty", exp_tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
